// File: rtl/pipe_pkg.sv
// Shared pipeline constants: the NOP encoding and the fetch/decode latch states.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic {
    ST_PAIR = 1'b0,
    ST_SOLO = 1'b1
  } fd_state_e;

endpackage

// File: rtl/fd_slot_reg.sv
// One fetch/decode slot: valid bit, instruction and PC with load/hold,
// clear-valid and synchronous reset.
module fd_slot_reg #(
  parameter int unsigned IW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic          d_valid,
  input  logic [IW-1:0] d_instr,
  input  logic [IW-1:0] d_pc,
  output logic          q_valid,
  output logic [IW-1:0] q_instr,
  output logic [IW-1:0] q_pc
);

  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [IW-1:0] pc_q, pc_d;

  // Clear only drops the valid bit; contents are masked downstream.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = d_valid;
      instr_d = d_instr;
      pc_d    = d_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign q_valid = valid_q;
  assign q_instr = instr_q;
  assign q_pc    = pc_q;

endmodule

// File: rtl/fd_pair_latch.sv
// Dual-issue fetch/decode latch: holds the fetched pair, applies hold, bubble,
// flush and younger-slot split, and gates fetch advance.
module fd_pair_latch
  import pipe_pkg::*;
#(
  parameter int unsigned IW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [IW-1:0] if_instr0,
  input  logic [IW-1:0] if_instr1,
  input  logic [IW-1:0] if_pc0,
  input  logic [IW-1:0] if_pc1,
  input  logic          fd_write,
  input  logic          bubble,
  input  logic          split_young,
  input  logic          flush,
  output logic [IW-1:0] fd_instr0,
  output logic [IW-1:0] fd_instr1,
  output logic [IW-1:0] fd_pc0,
  output logic [IW-1:0] fd_pc1,
  output logic          issue_valid0,
  output logic          issue_valid1,
  output logic          fetch_advance,
  output logic [CW-1:0] bubble_count
);

  fd_state_e     state_q, state_d;
  logic [CW-1:0] bubble_count_q, bubble_count_d;

  logic          fd_valid0, fd_valid1;
  logic [IW-1:0] instr0_q, instr1_q;
  logic          split_pair;
  logic          ld0, ld1, clr0, clr1;
  logic          d_valid0;
  logic [IW-1:0] d_instr0, d_pc0;

  assign split_pair = split_young && (state_q == ST_PAIR);

  // Slot steering: flush > hold > split-replay > normal load.
  always_comb begin
    state_d  = state_q;
    ld0      = 1'b0;
    ld1      = 1'b0;
    clr0     = 1'b0;
    clr1     = 1'b0;
    d_valid0 = if_valid;
    d_instr0 = if_instr0;
    d_pc0    = if_pc0;
    if (flush) begin
      clr0    = 1'b1;
      clr1    = 1'b1;
      state_d = ST_PAIR;
    end else if (fd_write) begin
      if (split_pair && fd_valid1) begin
        ld0      = 1'b1;
        clr1     = 1'b1;
        d_valid0 = 1'b1;
        d_instr0 = instr1_q;
        d_pc0    = fd_pc1;
        state_d  = ST_SOLO;
      end else begin
        ld0     = 1'b1;
        ld1     = 1'b1;
        state_d = ST_PAIR;
      end
    end
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (bubble && (bubble_count_q != {CW{1'b1}})) begin
      bubble_count_d = bubble_count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_PAIR;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  fd_slot_reg #(.IW(IW)) u_slot0 (
    .clock   (clock),
    .reset   (reset),
    .load    (ld0),
    .clear   (clr0),
    .d_valid (d_valid0),
    .d_instr (d_instr0),
    .d_pc    (d_pc0),
    .q_valid (fd_valid0),
    .q_instr (instr0_q),
    .q_pc    (fd_pc0)
  );

  fd_slot_reg #(.IW(IW)) u_slot1 (
    .clock   (clock),
    .reset   (reset),
    .load    (ld1),
    .clear   (clr1),
    .d_valid (if_valid),
    .d_instr (if_instr1),
    .d_pc    (if_pc1),
    .q_valid (fd_valid1),
    .q_instr (instr1_q),
    .q_pc    (fd_pc1)
  );

  // Issue/advance are combinational: the hazard unit already registers its stall.
  assign fd_instr0     = fd_valid0 ? instr0_q : IW'(NOP);
  assign fd_instr1     = fd_valid1 ? instr1_q : IW'(NOP);
  assign issue_valid0  = fd_valid0 && !bubble;
  assign issue_valid1  = fd_valid1 && !bubble && !split_pair;
  assign fetch_advance = fd_write && !(split_pair && fd_valid1) && !reset;
  assign bubble_count  = bubble_count_q;

endmodule

// File: doc/fd_pair_latch.md
# fd_pair_latch

Dual-issue fetch/decode pipeline latch for the 2-wide processor, and the consumer of the hazard unit's stall controls. It holds the fetched instruction pair (older slot 0, younger slot 1) between fetch and decode. It applies hold, bubble, flush and younger-slot split requests, and tells fetch whether the PC may advance. It also keeps a saturating count of bubble cycles for performance runs.

## Interface
Parameters:
- `IW`, default 32: instruction and PC width.
- `CW`, default 16: bubble counter width.

Ports:
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `if_valid`, in, 1: a fetched pair is presented this cycle.
- `if_instr0`, `if_instr1`, in, IW each: older and younger fetched instructions.
- `if_pc0`, `if_pc1`, in, IW each: PCs of the two fetched instructions.
- `fd_write`, in, 1: hazard unit permits the latch to update; 0 means hold.
- `bubble`, in, 1: present NOPs to decode/DX this cycle.
- `split_young`, in, 1: intra-pair dependency; issue the older slot only and replay the younger.
- `flush`, in, 1: taken branch or jump; discard the latched pair.
- `fd_instr0`, `fd_instr1`, out, IW each: latched instructions.
- `fd_pc0`, `fd_pc1`, out, IW each: latched PCs.
- `issue_valid0`, `issue_valid1`, out, 1 each: the slot issues to DX this cycle.
- `fetch_advance`, out, 1: fetch may advance the PC this cycle.
- `bubble_count`, out, CW: saturating count of cycles with `bubble`=1.

## Operation
- State register values: `PAIR` (normal) and `SOLO` (slot 0 holds a replayed younger instruction; slot 1 is empty).
- Per-slot latched state is valid bit, instruction and PC. An invalid slot drives the `NOP` constant on `fd_instrN`.
- Issue outputs:
  - `issue_valid0` = `fd_valid0` & ~`bubble`.
  - `issue_valid1` = `fd_valid1` & ~`bubble` & ~(`split_young` & `state`==`PAIR`).
- `fetch_advance` = `fd_write` & ~(`split_young` & `state`==`PAIR` & `fd_valid1`) & ~`reset`.
- Next-state priority, highest first:
  1. `reset`: both slots invalid, instructions and PCs set to 0, `state` = `PAIR`, `bubble_count` = 0.
  2. `flush`: both valid bits cleared, `state` = `PAIR`. This overrides `fd_write`=0 and `split_young`.
  3. `fd_write`=0: all slot state and `state` held.
  4. `split_young`=1, `state`=`PAIR`, `fd_valid1`=1: slot 0 takes slot 1's contents, slot 1 is invalidated, `state` = `SOLO`, and `if_*` is ignored.
  5. Otherwise: slots load `if_instr*` and `if_pc*`, both valid bits are set to `if_valid`, and `state` = `PAIR`.
- In `SOLO`, `split_young` is ignored and the next load returns to `PAIR`.
- `split_young` with `fd_valid1`=0 is treated as a normal load.
- `bubble_count` increments when `bubble`=1 and saturates at all-ones. It is not affected by `flush`.

## Timing
- Latency of 1 cycle: a pair accepted at edge N is on `fd_*` after edge N.
- `issue_valid*` and `fetch_advance` are combinational from the current-cycle controls and latched state. There is no extra register, because the hazard unit already registers its stall.
- After a split the younger instruction issues alone in the next cycle, provided `fd_write`=1. This costs 1 lost issue slot and 1 held fetch cycle.
- Reset values: `fd_instr*` = `NOP`, `fd_pc*` = 0, `issue_valid*` = 0, `fetch_advance` = 0, `bubble_count` = 0.
- A reset asserted in `SOLO` discards the pending younger instruction.

## Structure
- Shared package `pipe_pkg`:
  - `NOP` constant (32'h0).
  - State encodings `ST_PAIR` = 1'b0 and `ST_SOLO` = 1'b1.
- One sub-module, `fd_slot_reg`: valid, instruction and PC register with load/hold, clear-valid and synchronous reset. It is instantiated twice.
- The top level contains the state register, slot steering mux, issue/advance logic and the counter.

## Test plan
- Reset, then 3 pairs with `if_valid`=1 and `fd_write`=1 → pairs appear one cycle later. PCs are 0x10/0x11, 0x12/0x13, 0x14/0x15. Both `issue_valid` are 1 and `fetch_advance` stays 1.
- Hold 2 cycles with `fd_write`=0 and `bubble`=1 → `fd_*` unchanged, `issue_valid*` = 0, `fetch_advance` = 0, `bubble_count` = 2.
- Pair (A,B) with `split_young`=1 → A issues alone and `fetch_advance` = 0. Next cycle: `fd_instr0`=B, `issue_valid1`=0, `state`=`SOLO`. The following cycle loads the new fetch pair.
- `flush` together with `fd_write`=0 → both valid bits are 0 next cycle and `fd_instr*` = `NOP`.
- `reset` asserted while in `SOLO` → B is lost and all outputs take their reset values next cycle.
- `bubble` held for 2^CW+3 cycles with CW=4 → `bubble_count` saturates at 15.
